// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data, redirect request and the decoded-bundle handshake.
// master is the fetch stage; slave is the ROM/decode/branch side.
interface instr_fetch_if;
    logic [15:0] rom_addr;
    logic [15:0] rom_out;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_opcode;
    logic [15:0] ir_src_ext;
    logic [15:0] ir_dst_ext;
    logic        ir_has_src_ext;
    logic        ir_has_dst_ext;
    logic [15:0] ir_pc;
    logic [15:0] ir_next_pc;
    logic        ir_illegal;

    modport master (
        output rom_addr,
        input  rom_out,
        input  redirect_valid,
        input  redirect_pc,
        output ir_valid,
        input  ir_ready,
        output ir_opcode,
        output ir_src_ext,
        output ir_dst_ext,
        output ir_has_src_ext,
        output ir_has_dst_ext,
        output ir_pc,
        output ir_next_pc,
        output ir_illegal
    );

    modport slave (
        input  rom_addr,
        output rom_out,
        output redirect_valid,
        output redirect_pc,
        input  ir_valid,
        output ir_ready,
        input  ir_opcode,
        input  ir_src_ext,
        input  ir_dst_ext,
        input  ir_has_src_ext,
        input  ir_has_dst_ext,
        input  ir_pc,
        input  ir_next_pc,
        input  ir_illegal
    );
endinterface

// File: rtl/instr_fetch.sv
// MSP430 instruction fetch: walks the PC through the ROM, assembling opcode plus
// up to two extension words into one bundle handed to decode with valid/ready.
module instr_fetch #(
    parameter logic [15:0] PC_RESET = 16'hc000
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    typedef enum logic [1:0] {FETCH_OP, FETCH_SRC, FETCH_DST, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] r_opcode;
    logic [15:0] r_src_ext;
    logic [15:0] r_dst_ext;
    logic        r_has_src;
    logic        r_has_dst;
    logic [15:0] r_ir_pc;
    logic        r_illegal;

    logic        w_fmt1;
    logic        w_fmt2;
    logic        w_need_src;
    logic        w_need_dst;
    logic        w_illegal;
    logic        w_cap_op;
    logic        w_cap_src;
    logic        w_cap_dst;

    // Source extension: indexed/symbolic/absolute (As=01 except R3 constant) or immediate (@PC+).
    function automatic logic src_rule(input logic [1:0] as_mode, input logic [3:0] rs);
        return ((as_mode == 2'b01) && (rs != 4'd3)) || ((as_mode == 2'b11) && (rs == 4'd0));
    endfunction

    always_comb begin
        w_fmt1     = (bus.rom_out[15:12] >= 4'd4);
        w_fmt2     = (bus.rom_out[15:10] == 6'b000100);
        w_illegal  = (bus.rom_out[15:10] < 6'd4);
        w_need_src = 1'b0;
        if (w_fmt1) begin
            w_need_src = src_rule(bus.rom_out[5:4], bus.rom_out[11:8]);
        end else if (w_fmt2) begin
            w_need_src = src_rule(bus.rom_out[5:4], bus.rom_out[3:0]);
        end
        w_need_dst = w_fmt1 && bus.rom_out[7];
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cap_op     = 1'b0;
        w_cap_src    = 1'b0;
        w_cap_dst    = 1'b0;
        case (r_state)
            FETCH_OP: begin
                w_cap_op  = 1'b1;
                w_pc_next = r_pc + 16'd2;
                if (w_need_src) begin
                    w_state_next = FETCH_SRC;
                end else if (w_need_dst) begin
                    w_state_next = FETCH_DST;
                end else begin
                    w_state_next = HOLD;
                end
            end
            FETCH_SRC: begin
                w_cap_src    = 1'b1;
                w_pc_next    = r_pc + 16'd2;
                w_state_next = r_has_dst ? FETCH_DST : HOLD;
            end
            FETCH_DST: begin
                w_cap_dst    = 1'b1;
                w_pc_next    = r_pc + 16'd2;
                w_state_next = HOLD;
            end
            HOLD: begin
                if (bus.ir_ready) begin
                    w_state_next = FETCH_OP;
                end
            end
            default: w_state_next = FETCH_OP;
        endcase
        // A redirect kills any partial bundle; a same-cycle handshake has already completed.
        if (bus.redirect_valid) begin
            w_state_next = FETCH_OP;
            w_pc_next    = bus.redirect_pc & 16'hfffe;
            w_cap_op     = 1'b0;
            w_cap_src    = 1'b0;
            w_cap_dst    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_OP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= PC_RESET;
            r_opcode  <= 16'h0000;
            r_src_ext <= 16'h0000;
            r_dst_ext <= 16'h0000;
            r_has_src <= 1'b0;
            r_has_dst <= 1'b0;
            r_ir_pc   <= 16'h0000;
            r_illegal <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_cap_op) begin
                r_opcode  <= bus.rom_out;
                r_ir_pc   <= r_pc;
                r_src_ext <= 16'h0000;
                r_dst_ext <= 16'h0000;
                r_has_src <= w_need_src;
                r_has_dst <= w_need_dst;
                r_illegal <= w_illegal;
            end
            if (w_cap_src) begin
                r_src_ext <= bus.rom_out;
            end
            if (w_cap_dst) begin
                r_dst_ext <= bus.rom_out;
            end
        end
    end

    assign bus.rom_addr       = r_pc;
    assign bus.ir_valid       = (r_state == HOLD);
    assign bus.ir_opcode      = r_opcode;
    assign bus.ir_src_ext     = r_src_ext;
    assign bus.ir_dst_ext     = r_dst_ext;
    assign bus.ir_has_src_ext = r_has_src;
    assign bus.ir_has_dst_ext = r_has_dst;
    assign bus.ir_pc          = r_ir_pc;
    assign bus.ir_next_pc     = (r_state == HOLD) ? r_pc : 16'h0000;
    assign bus.ir_illegal     = r_illegal;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of single-bundle vectors, directed multi-cycle
// sequences, then random ROM/ready/redirect traffic against an instruction-level model.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if bus();
    instr_fetch #(.PC_RESET(16'hc000)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] rom [0:32767];
    assign bus.rom_out = rom[bus.rom_addr[15:1]];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] op;
        logic [15:0] w1;
        logic [15:0] w2;
        logic        hs;
        logic        hd;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] op;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] nxt;
        logic        hs;
        logic        hd;
        logic        ill;
    } bundle_t;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        check16("rst_rom_addr", bus.rom_addr, 16'hc000);
        check16("rst_valid", {15'b0, bus.ir_valid}, 16'h0);
        check16("rst_opcode", bus.ir_opcode, 16'h0);
        check16("rst_src", bus.ir_src_ext, 16'h0);
        check16("rst_dst", bus.ir_dst_ext, 16'h0);
        check16("rst_flags", {13'b0, bus.ir_has_src_ext, bus.ir_has_dst_ext, bus.ir_illegal}, 16'h0);
        check16("rst_ir_pc", bus.ir_pc, 16'h0);
        check16("rst_next_pc", bus.ir_next_pc, 16'h0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.ir_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Instruction-level view of the program: what bundle starts at pc.
    function automatic bundle_t ref_bundle(input logic [15:0] pc);
        bundle_t b;
        int op, as_mode, rs;
        logic need_src, need_dst;
        logic [15:0] a;
        op = int'(rom[pc[15:1]]);
        as_mode = (op >> 4) & 3;
        need_src = 1'b0;
        need_dst = 1'b0;
        if ((op >> 12) >= 4) begin
            rs = (op >> 8) & 15;
            need_src = (as_mode == 1 && rs != 3) || (as_mode == 3 && rs == 0);
            need_dst = ((op >> 7) & 1) == 1;
        end else if ((op >> 10) == 4) begin
            rs = op & 15;
            need_src = (as_mode == 1 && rs != 3) || (as_mode == 3 && rs == 0);
        end
        b.pc  = pc;
        b.op  = rom[pc[15:1]];
        b.ill = ((op >> 10) < 4);
        b.hs  = need_src;
        b.hd  = need_dst;
        b.src = 16'h0;
        b.dst = 16'h0;
        a = pc + 16'd2;
        if (need_src) begin
            b.src = rom[a[15:1]];
            a = a + 16'd2;
        end
        if (need_dst) begin
            b.dst = rom[a[15:1]];
            a = a + 16'd2;
        end
        b.nxt = a;
        return b;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        int cyc;
        int n_xfer;
        logic r, rd;
        logic [15:0] tgt, model_pc;
        logic [15:0] exp_src, exp_dst;
        bundle_t exp_b, act_b;

        rst = 1'b1;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;

        vecs[0]  = '{16'h4405, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{16'h40B2, 16'h1234, 16'h0200, 1'b1, 1'b1, 1'b0, 3};
        vecs[2]  = '{16'h4315, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{16'h4292, 16'h0400, 16'h0402, 1'b1, 1'b1, 1'b0, 3};
        vecs[4]  = '{16'h4222, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{16'h4232, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{16'h4582, 16'h0010, 16'h2222, 1'b0, 1'b1, 1'b0, 2};
        vecs[7]  = '{16'h1290, 16'h0008, 16'h2222, 1'b1, 1'b0, 1'b0, 2};
        vecs[8]  = '{16'h1230, 16'hABCD, 16'h2222, 1'b1, 1'b0, 1'b0, 2};
        vecs[9]  = '{16'h20B0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{16'h0C30, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1};
        vecs[11] = '{16'h0000, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1};
        vecs[12] = '{16'h4395, 16'h0300, 16'h2222, 1'b0, 1'b1, 1'b0, 2};
        vecs[13] = '{16'h4015, 16'h0066, 16'h2222, 1'b1, 1'b0, 1'b0, 2};

        for (int v = 0; v < 14; v++) begin
            rom[16'hc000 >> 1] = vecs[v].op;
            rom[16'hc002 >> 1] = vecs[v].w1;
            rom[16'hc004 >> 1] = vecs[v].w2;
            bus.ir_ready = 1'b1;
            do_reset();
            wait_valid(cyc);
            exp_src = vecs[v].hs ? vecs[v].w1 : 16'h0;
            exp_dst = vecs[v].hd ? (vecs[v].hs ? vecs[v].w2 : vecs[v].w1) : 16'h0;
            check16($sformatf("v%0d_latency", v), 16'(cyc), 16'(vecs[v].lat));
            check16($sformatf("v%0d_opcode", v), bus.ir_opcode, vecs[v].op);
            check16($sformatf("v%0d_src", v), bus.ir_src_ext, exp_src);
            check16($sformatf("v%0d_dst", v), bus.ir_dst_ext, exp_dst);
            check16($sformatf("v%0d_flags", v),
                    {13'b0, bus.ir_has_src_ext, bus.ir_has_dst_ext, bus.ir_illegal},
                    {13'b0, vecs[v].hs, vecs[v].hd, vecs[v].ill});
            check16($sformatf("v%0d_ir_pc", v), bus.ir_pc, 16'hc000);
            check16($sformatf("v%0d_next_pc", v), bus.ir_next_pc, 16'(16'hc000 + 2 * vecs[v].lat));
            $display("vector %0d op=%h lat=%0d next=%h", v, bus.ir_opcode, cyc, bus.ir_next_pc);
        end

        // Backpressure: bundle and PC frozen while ir_ready is low.
        rom[16'hc000 >> 1] = 16'h4405;
        rom[16'hc002 >> 1] = 16'h4315;
        bus.ir_ready = 1'b0;
        do_reset();
        wait_valid(cyc);
        for (int k = 0; k < 5; k++) begin
            check16("bp_valid", {15'b0, bus.ir_valid}, 16'h1);
            check16("bp_opcode", bus.ir_opcode, 16'h4405);
            check16("bp_ir_pc", bus.ir_pc, 16'hc000);
            check16("bp_next_pc", bus.ir_next_pc, 16'hc002);
            check16("bp_rom_addr", bus.rom_addr, 16'hc002);
            @(negedge clk);
        end
        bus.ir_ready = 1'b1;
        @(negedge clk);
        check16("bp_release_valid", {15'b0, bus.ir_valid}, 16'h0);
        check16("bp_release_rom_addr", bus.rom_addr, 16'hc002);
        @(negedge clk);
        check16("bp_next_opcode", bus.ir_opcode, 16'h4315);
        check16("bp_next_ir_pc", bus.ir_pc, 16'hc002);
        $display("backpressure sequence done");

        // Redirect while fetching the source extension.
        rom[16'hc000 >> 1] = 16'h40B2;
        rom[16'hc002 >> 1] = 16'h1234;
        rom[16'hc004 >> 1] = 16'h0200;
        rom[16'hc100 >> 1] = 16'h4405;
        do_reset();
        @(negedge clk);
        check16("rd_src_phase_addr", bus.rom_addr, 16'hc002);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hc101;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check16("rd_rom_addr", bus.rom_addr, 16'hc100);
        check16("rd_valid", {15'b0, bus.ir_valid}, 16'h0);
        @(negedge clk);
        check16("rd_bundle_valid", {15'b0, bus.ir_valid}, 16'h1);
        check16("rd_ir_pc", bus.ir_pc, 16'hc100);
        check16("rd_opcode", bus.ir_opcode, 16'h4405);
        check16("rd_next_pc", bus.ir_next_pc, 16'hc102);
        $display("redirect to c101 done ir_pc=%h", bus.ir_pc);

        // Redirect to FFFE (also coinciding with a handshake): extension wraps to 0000.
        rom[16'hfffe >> 1] = 16'h4035;
        rom[0] = 16'h5A5A;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hfffe;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check16("wrap_rom_addr", bus.rom_addr, 16'hfffe);
        check16("wrap_valid_low", {15'b0, bus.ir_valid}, 16'h0);
        wait_valid(cyc);
        check16("wrap_latency", 16'(cyc), 16'd2);
        check16("wrap_ir_pc", bus.ir_pc, 16'hfffe);
        check16("wrap_src", bus.ir_src_ext, 16'h5A5A);
        check16("wrap_has_src", {15'b0, bus.ir_has_src_ext}, 16'h1);
        check16("wrap_next_pc", bus.ir_next_pc, 16'h0002);
        $display("redirect to fffe done next=%h", bus.ir_next_pc);

        // Reset mid-instruction wins over a simultaneous redirect.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hc000;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check16("mid_src_phase_addr", bus.rom_addr, 16'hc002);
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h4000;
        @(negedge clk);
        check16("mid_rst_rom_addr", bus.rom_addr, 16'hc000);
        check16("mid_rst_valid", {15'b0, bus.ir_valid}, 16'h0);
        check16("mid_rst_opcode", bus.ir_opcode, 16'h0);
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        $display("reset mid-instruction done");

        // Random program, ready and redirects against the instruction-level model.
        for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
        bus.ir_ready = 1'b1;
        do_reset();
        model_pc = 16'hc000;
        n_xfer = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            r  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 15) == 0);
            tgt = 16'($urandom);
            bus.ir_ready = r;
            bus.redirect_valid = rd;
            bus.redirect_pc = tgt;
            if (bus.ir_valid && r) begin
                exp_b = ref_bundle(model_pc);
                act_b = '{bus.ir_pc, bus.ir_opcode, bus.ir_src_ext, bus.ir_dst_ext, bus.ir_next_pc,
                          bus.ir_has_src_ext, bus.ir_has_dst_ext, bus.ir_illegal};
                n_cmp++;
                if (act_b !== exp_b) begin
                    n_err++;
                    $display("FAIL rand_bundle: got %h expected %h", act_b, exp_b);
                end
                $display("xfer %0d pc=%h op=%h next=%h", n_xfer, act_b.pc, act_b.op, act_b.nxt);
                model_pc = exp_b.nxt;
                n_xfer++;
            end
            if (rd) model_pc = tgt & 16'hfffe;
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_cmp++;
        if (n_xfer < 200) begin
            n_err++;
            $display("FAIL rand_xfer_count: got %0d expected at least 200", n_xfer);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the MSP430 model. Owns the program counter, drives the word address into the combinational program ROM, and captures the returned 16-bit words. It assembles one complete instruction bundle per fetch: the opcode plus zero, one or two extension words, as required by the MSP430 addressing modes. The bundle is presented to decode with a valid/ready handshake. It sits directly upstream of the ROM, which it addresses, and directly downstream of the ROM, whose output it consumes.

## Interface
- `PC_RESET`, default 16'hc000: PC value loaded on reset (base of ROM window).
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `rom_addr`  out  16: byte address of word to fetch; always even; equals `pc`.
- `rom_out`  in  16: word returned combinationally by ROM for `rom_addr`.
- `redirect_valid`  in  1: load new PC (jump/branch/interrupt), discard in-flight bundle.
- `redirect_pc`  in  16: target address; bit 0 ignored (forced to 0).
- `ir_valid`  out  1: bundle below is complete and stable.
- `ir_ready`  in  1: decode accepts bundle this cycle.
- `ir_opcode`  out  16: first instruction word.
- `ir_src_ext`  out  16: source extension word (0 if none).
- `ir_dst_ext`  out  16: destination extension word (0 if none).
- `ir_has_src_ext`  out  1 / `ir_has_dst_ext`  out  1: extension present flags.
- `ir_pc`  out  16: address of the opcode word.
- `ir_next_pc`  out  16: address following the last word of the bundle.
- `ir_illegal`  out  1: opcode[15:10] in 6'b000000..6'b000011 (unimplemented encoding); fetched with no extensions.

## Operation
- States: FETCH_OP, FETCH_SRC, FETCH_DST, HOLD.
- FETCH_OP: `rom_addr=pc`. Capture `rom_out` into opcode; `ir_pc<=pc`; `pc<=pc+2`. Decode extension needs from the captured word and go to FETCH_SRC if src needed, else FETCH_DST if dst needed, else HOLD.
- Format I (opcode[15:12]>=4): As=[5:4], Ad=[7], Rs=[11:8].
  - src ext when (As==01 && Rs!=3) or (As==11 && Rs==0).
  - dst ext when Ad==1.
- Format II (opcode[15:10]==6'b000100): src ext rule as above with Rs=opcode[3:0]; no dst ext.
- Jumps (opcode[15:13]==3'b001): no extensions.
- Constant generator encodings R2/As=10,11 and R3/any As need no extension; R2/As=01 (absolute) does.
- FETCH_SRC: capture `ir_src_ext`, `pc+=2`, go to FETCH_DST if dst needed, else HOLD.
- FETCH_DST: capture `ir_dst_ext`, `pc+=2`, go to HOLD.
- HOLD: `ir_valid=1`; `ir_next_pc=pc`.
  - If `ir_ready`, transfer completes; go to FETCH_OP, `ir_valid` deasserts next cycle.
  - Otherwise all `ir_*` outputs and `pc` stay frozen.
- Unused extension fields and flags are cleared to 0 when a new opcode is captured.
- Arithmetic: `pc` is 16-bit and wraps at 16'hfffe+2 -> 16'h0000. Bit 0 is always 0.

## Timing
- Reset (rst sampled high): `pc=PC_RESET`, state FETCH_OP, `ir_valid=0`, all `ir_*` data outputs and flags 0, `rom_addr=PC_RESET`.
- Latency from entering FETCH_OP to `ir_valid`: 1 cycle for 1-word, 2 cycles for 2-word, 3 cycles for 3-word instructions.
- Throughput with `ir_ready` held high: one instruction per (words+1) cycles.
- `redirect_valid` has priority over every state transition. Next cycle:
  - `pc=redirect_pc & 16'hfffe`, state FETCH_OP, `ir_valid=0`.
  - Any partial bundle is discarded.
- Redirect in the same cycle as `ir_valid&&ir_ready`: the handshake counts as a completed transfer, then the redirect applies.
- `rst` mid-instruction: abandon the bundle; apply reset values next cycle regardless of `redirect_valid`.
- `rom_addr` is combinational from `pc` only; no combinational path from `ir_ready` or `redirect_*` to `rom_addr`.

## Test plan
- Reset: hold `rst` 2 cycles. Required: `rom_addr=16'hc000`, `ir_valid=0`, all `ir_*`=0. First fetch occurs in the cycle after release.
- One-word instruction: ROM[C000]=16'h4405 (MOV R4,R5), `ir_ready=1`. Required: `ir_valid` 1 cycle after release, `ir_opcode=4405`, both ext flags 0, `ir_pc=C000`, `ir_next_pc=C002`.
- Three-word instruction: ROM words 16'h40B2, 16'h1234, 16'h0200 (MOV #0x1234,&0x0200). Required: `ir_valid` after 3 cycles, `src_ext=1234`, `dst_ext=0200`, both flags 1, `ir_next_pc=C006`.
- Constant generator: opcode 16'h4315 (MOV #1,R5). Required: no extension fetched, `ir_next_pc=ir_pc+2`.
- Backpressure: `ir_ready=0` for 5 cycles in HOLD. Required: all `ir_*`, `rom_addr` and `pc` constant. Raising `ir_ready` moves to FETCH_OP next cycle.
- Redirect: assert `redirect_valid` with `redirect_pc=16'hc101` during FETCH_SRC. Required: next cycle `rom_addr=C100`, `ir_valid` stays 0, next bundle `ir_pc=C100`. Also cover `redirect_pc=FFFE` with a 2-word instruction: the extension is read at 0000 and `ir_next_pc=0002`.
